led_pwm_ctrl: RTL and testbench



---
 rtl/gpio_pkg.sv | 14 +
 rtl/led_pwm_ctrl_if.sv | 30 +++
 rtl/led_pwm_ctrl_tick_gen.sv | 28 ++
 rtl/led_pwm_ctrl.sv | 108 ++++++++++
 tb/tb_led_pwm_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO LED path: parameter defaults and reset values.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_pkg;

   localparam int N_LED_DEF      = 8;
   localparam int PWM_BITS_DEF   = 8;
   localparam int PRESC_BITS_DEF = 16;
   localparam int BLINK_BITS     = 8;

   localparam logic BLINK_PHASE_RST = 1'b1;
   localparam logic LED_OUT_RST     = 1'b0;

endpackage

// File: rtl/led_pwm_ctrl_if.sv
// Register-map side bundle of the LED PWM controller: requests/config in, pin drive out.
// Latency: n/a (wires only).
// Backpressure: none; config is sampled at frame boundaries, outputs are free-running.
interface led_pwm_ctrl_if import gpio_pkg::*; #(
   parameter int N_LED      = N_LED_DEF,
   parameter int PWM_BITS   = PWM_BITS_DEF,
   parameter int PRESC_BITS = PRESC_BITS_DEF
);

   logic [N_LED-1:0]      led_in;
   logic [PWM_BITS-1:0]   duty;
   logic [PRESC_BITS-1:0] presc;
   logic [N_LED-1:0]      blink_ena;
   logic [BLINK_BITS-1:0] blink_period;
   logic [N_LED-1:0]      led_out;
   logic                  frame_strobe;

   // register map side
   modport master (
      output led_in, duty, presc, blink_ena, blink_period,
      input  led_out, frame_strobe
   );

   // LED controller side
   modport slave (
      input  led_in, duty, presc, blink_ena, blink_period,
      output led_out, frame_strobe
   );

endinterface

// File: rtl/led_pwm_ctrl_tick_gen.sv
// Prescaler: emits a one-cycle tick every presc+1 cycles (presc = 0 -> every cycle).
// Latency: tick is combinational from the count; the count wraps on the cycle after tick.
// Backpressure: none; a reduced presc makes the >= compare wrap at once, so it never overruns.
module tick_gen #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] presc,
   output logic         tick
);

   logic [W-1:0] presc_cnt;

   assign tick = (presc_cnt >= presc);

   // free-running divider count, cleared on every tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_cnt <= '0;
      end else if (tick) begin
         presc_cnt <= '0;
      end else begin
         presc_cnt <= presc_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/led_pwm_ctrl.sv
// LED driver: shared PWM brightness plus optional per-LED blink (macro LED_PWM_BLINK_EN).
// Latency: config lands at the frame-end shadow load; led_out registered 1 cycle after compare.
// Backpressure: none; inputs are sampled only at frame boundaries so pins never glitch.
module led_pwm_ctrl import gpio_pkg::*; #(
   parameter int N_LED      = N_LED_DEF,
   parameter int PWM_BITS   = PWM_BITS_DEF,
   parameter int PRESC_BITS = PRESC_BITS_DEF
) (
   input  logic          ACLK,
   input  logic          ARESETn,
   led_pwm_ctrl_if.slave bus
);

   logic                  tick;
   logic                  frame_end;
   logic                  pwm_on;
   logic [PWM_BITS-1:0]   pwm_cnt;
   logic [N_LED-1:0]      led_sh;
   logic [PWM_BITS-1:0]   duty_sh;
   logic [N_LED-1:0]      blink_mask;
   logic [N_LED-1:0]      led_out_q;
   logic                  frame_strobe_q;

   tick_gen #(.W(PRESC_BITS)) u_tick_gen (
      .clk   (ACLK),
      .rst_n (ARESETn),
      .presc (bus.presc),
      .tick  (tick)
   );

   assign frame_end = tick & (&pwm_cnt);

   // all-ones duty means fully on, not (2^N-1)/2^N
   assign pwm_on = (&duty_sh) | (pwm_cnt < duty_sh);

   // PWM position within the frame, wraps naturally at all-ones
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         pwm_cnt <= '0;
      end else if (tick) begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   // double-buffered config: captured only at frame end, strobe follows one cycle later
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         led_sh         <= '0;
         duty_sh        <= '0;
         frame_strobe_q <= 1'b0;
      end else begin
         frame_strobe_q <= frame_end;
         if (frame_end) begin
            led_sh  <= bus.led_in;
            duty_sh <= bus.duty;
         end
      end
   end

`ifdef LED_PWM_BLINK_EN
   logic [N_LED-1:0]      blink_ena_sh;
   logic [BLINK_BITS-1:0] blink_period_sh;
   logic [BLINK_BITS-1:0] frame_cnt;
   logic                  blink_phase;

   // blink state; decisions use the period being loaded so on/off takes effect at this boundary
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         blink_ena_sh    <= '0;
         blink_period_sh <= '0;
         frame_cnt       <= '0;
         blink_phase     <= BLINK_PHASE_RST;
      end else if (frame_end) begin
         blink_ena_sh    <= bus.blink_ena;
         blink_period_sh <= bus.blink_period;
         if ((bus.blink_period == '0) || (bus.blink_period != blink_period_sh)) begin
            frame_cnt   <= '0;
            blink_phase <= BLINK_PHASE_RST;
         end else if ((frame_cnt + 1'b1) == bus.blink_period) begin
            frame_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            frame_cnt   <= frame_cnt + 1'b1;
         end
      end
   end

   assign blink_mask = ~blink_ena_sh | {N_LED{blink_phase}};
`else
   // blink inputs stay on the bus but have no effect in this build
   logic unused_blink;
   assign unused_blink = ^{bus.blink_ena, bus.blink_period};
   assign blink_mask   = {N_LED{BLINK_PHASE_RST}};
`endif

   // registered pin drive
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         led_out_q <= {N_LED{LED_OUT_RST}};
      end else begin
         led_out_q <= led_sh & {N_LED{pwm_on}} & blink_mask;
      end
   end

   assign bus.led_out      = led_out_q;
   assign bus.frame_strobe = frame_strobe_q;

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl: directed frame-level sequences plus random config.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_pwm_ctrl;
   import gpio_pkg::*;

   localparam int NL    = 8;
   localparam int PB    = 8;
   localparam int PRB   = 16;
   localparam int FRAME = 256;

   logic ACLK    = 1'b0;
   logic ARESETn = 1'b0;

   led_pwm_ctrl_if #(.N_LED(NL), .PWM_BITS(PB), .PRESC_BITS(PRB)) bus ();

   led_pwm_ctrl #(.N_LED(NL), .PWM_BITS(PB), .PRESC_BITS(PRB)) dut (
      .ACLK    (ACLK),
      .ARESETn (ARESETn),
      .bus     (bus)
   );

   always #5 ACLK = ~ACLK;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Time-level view: ticks happen when enough cycles have elapsed, frame position is the tick
   // count modulo the frame length, blink phase is derived from frames elapsed since the period
   // was last (re)loaded.
   int         m_cnt    = 0;   // cycles since last tick
   int         m_pos    = 0;   // tick index within the frame
   int         m_frames = 0;   // frames since blink period was loaded
   logic [7:0] m_led    = '0;
   logic [7:0] m_duty   = '0;
   logic [7:0] m_bena   = '0;
   logic [7:0] m_bper   = '0;

   function automatic logic [7:0] model_out();
      logic [7:0] mask;
      logic       ph;
      bit         on;
`ifdef LED_PWM_BLINK_EN
      ph   = (m_bper == 0) ? 1'b1 : (((m_frames / int'(m_bper)) % 2) == 0);
      mask = ~m_bena | {8{ph}};
`else
      ph   = 1'b1;
      mask = {8{ph}};
`endif
      on = (m_duty == 8'hFF) || (m_pos < int'(m_duty));
      return on ? (m_led & mask) : 8'h00;
   endfunction

   always begin
      logic [7:0] exp_led;
      logic       exp_stb;
      bit         tk, fe;
      @(posedge ACLK);
      if (!ARESETn) begin
         m_cnt = 0; m_pos = 0; m_frames = 0;
         m_led = '0; m_duty = '0; m_bena = '0; m_bper = '0;
         exp_led = 8'h00;
         exp_stb = 1'b0;
      end else begin
         tk      = (m_cnt >= int'(bus.presc));
         fe      = tk && (m_pos == FRAME - 1);
         exp_led = model_out();
         exp_stb = fe;
         m_cnt   = tk ? 0 : m_cnt + 1;
         if (tk) m_pos = (m_pos + 1) % FRAME;
         if (fe) begin
            if (bus.blink_period != m_bper) m_frames = 0;
            else m_frames++;
            m_led  = bus.led_in;
            m_duty = bus.duty;
            m_bena = bus.blink_ena;
            m_bper = bus.blink_period;
         end
      end
      #1;
      check("model_led_out", 32'(bus.led_out), 32'(exp_led));
      check("model_frame_strobe", 32'(bus.frame_strobe), 32'(exp_stb));
   end

   // ---------------- helpers ----------------
   task automatic wait_strobe(input int budget, output int cyc);
      cyc = 0;
      do begin
         @(posedge ACLK); #1;
         cyc++;
      end while (!bus.frame_strobe && cyc < budget);
      if (!bus.frame_strobe) begin
         n_chk++;
         $display("FAIL strobe_timeout: no frame_strobe within %0d cycles", budget);
      end
   endtask

   typedef struct {
      logic [7:0] led;
      logic [7:0] duty;
      int         exp_hi;
   } vec_t;

   // ---------------- directed + random stimulus ----------------
   initial begin
      vec_t       vecs[7];
      int         cyc, nz, hi, lo;
      logic [7:0] first, exp_b;
      int         r;

      vecs[0] = '{8'hA5, 8'hFF, 256};
      vecs[1] = '{8'hFF, 8'h40, 64};
      vecs[2] = '{8'h3C, 8'h00, 0};
      vecs[3] = '{8'h81, 8'h01, 1};
      vecs[4] = '{8'hFF, 8'hFE, 254};
      vecs[5] = '{8'h5A, 8'hC0, 192};
      vecs[6] = '{8'h01, 8'h80, 128};

      bus.led_in       = 8'hA5;
      bus.duty         = 8'hFF;
      bus.presc        = '0;
      bus.blink_ena    = '0;
      bus.blink_period = '0;

      // reset state
      repeat (3) @(negedge ACLK);
      check("rst_led_out", 32'(bus.led_out), 32'h0);
      check("rst_frame_strobe", 32'(bus.frame_strobe), 32'h0);
      ARESETn = 1'b1;

      // full on: dark for the first frame, then constant A5
      cyc = 0; nz = 0;
      while (cyc < 300) begin
         @(posedge ACLK); #1;
         cyc++;
         if (bus.frame_strobe) break;
         if (bus.led_out != 0) nz++;
      end
      check("first_strobe_cycles", cyc, 256);
      check("first_frame_dark", nz, 0);
      @(posedge ACLK); #1;
      check("full_on_after_strobe", 32'(bus.led_out), 32'hA5);

      // duty table: high time per frame, starting at pwm position 0
      for (int i = 0; i < 7; i++) begin
         @(negedge ACLK);
         bus.led_in = vecs[i].led;
         bus.duty   = vecs[i].duty;
         wait_strobe(600, cyc);
         hi = 0; lo = 0; first = '0;
         for (int k = 0; k < FRAME; k++) begin
            @(posedge ACLK); #1;
            if (k == 0) first = bus.led_out;
            if (bus.led_out == vecs[i].led) hi++;
            else if (bus.led_out == 8'h00) lo++;
         end
         check("duty_hi_cycles", hi, vecs[i].exp_hi);
         check("duty_lo_cycles", lo, FRAME - vecs[i].exp_hi);
         if (vecs[i].exp_hi > 0) check("duty_first_hi", 32'(first), 32'(vecs[i].led));
      end

      // glitch-free update mid-frame
      @(negedge ACLK);
      bus.led_in = 8'hFF;
      bus.duty   = 8'h40;
      wait_strobe(600, cyc);
      hi = 0;
      for (int k = 0; k < 100; k++) begin
         @(posedge ACLK); #1;
         if (bus.led_out == 8'hFF) hi++;
      end
      @(negedge ACLK);
      bus.duty = 8'hC0;
      cyc = 0;
      while (cyc < 300) begin
         @(posedge ACLK); #1;
         cyc++;
         if (bus.led_out == 8'hFF) hi++;
         if (bus.frame_strobe) break;
      end
      check("glitch_cur_frame_hi", hi, 64);
      hi = 0;
      for (int k = 0; k < FRAME; k++) begin
         @(posedge ACLK); #1;
         if (bus.led_out == 8'hFF) hi++;
      end
      check("glitch_next_frame_hi", hi, 192);

      // blink: bit 0 on 2 frames / off 2 frames, bit 1 steady
      @(negedge ACLK);
      bus.led_in       = 8'h03;
      bus.duty         = 8'hFF;
      bus.blink_ena    = 8'h01;
      bus.blink_period = 8'd2;
      wait_strobe(600, cyc);
      for (int f = 0; f < 6; f++) begin
         repeat (128) @(posedge ACLK);
         #1;
`ifdef LED_PWM_BLINK_EN
         exp_b = (((f / 2) % 2) == 0) ? 8'h03 : 8'h02;
`else
         exp_b = 8'h03;
`endif
         check("blink_frame", 32'(bus.led_out), 32'(exp_b));
         wait_strobe(600, cyc);
      end
      @(negedge ACLK);
      bus.blink_ena    = '0;
      bus.blink_period = '0;

      // prescaler reduced from 3 to 1 while the count sits at 3
      bus.presc = 16'd3;
      for (int k = 0; k < 10; k++) begin
         @(posedge ACLK); #1;
         if (m_cnt == 3) break;
      end
      @(negedge ACLK);
      bus.presc = 16'd1;
      wait_strobe(3000, cyc);
      wait_strobe(3000, cyc);
      check("presc_reduced_frame_len", cyc, 512);

      // asynchronous reset in the middle of a lit frame
      wait_strobe(3000, cyc);
      repeat (50) @(posedge ACLK);
      #2;
      check("lit_before_reset", 32'(bus.led_out), 32'h03);
      ARESETn = 1'b0;
      #1;
      check("async_rst_led_out", 32'(bus.led_out), 32'h0);
      check("async_rst_strobe", 32'(bus.frame_strobe), 32'h0);
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETn = 1'b1;
      wait_strobe(3000, cyc);
      check("strobe_after_reset", cyc, 512);

      // random configuration, checked every cycle by the model
      for (int s = 0; s < 40; s++) begin
         @(negedge ACLK);
         r = $urandom_range(0, 5);
         bus.led_in       = 8'($urandom);
         bus.duty         = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
         bus.presc        = 16'($urandom_range(0, 3));
         bus.blink_ena    = 8'($urandom);
         bus.blink_period = 8'($urandom_range(0, 3));
         repeat ($urandom_range(50, 1200)) @(posedge ACLK);
      end

      @(negedge ACLK);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
